// File: rtl/issue_queue_allocator.sv
// issue_queue_allocator: circular free-list FIFO handing out issue-queue entries to dispatch lanes
module issue_queue_allocator #(
  parameter int ENTRY_NUM = 16,
  parameter int ALLOC_WIDTH = 2,
  parameter int RELEASE_WIDTH = 2,
  localparam int IW = $clog2(ENTRY_NUM),
  localparam int CW = IW + 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              stall,
  input  logic [ALLOC_WIDTH-1:0]            allocReq,
  output logic                              allocOK,
  output logic [ALLOC_WIDTH-1:0][IW-1:0]    allocPtr,
  input  logic [RELEASE_WIDTH-1:0]          releaseReq,
  input  logic [RELEASE_WIDTH-1:0][IW-1:0]  releasePtr,
  output logic [CW-1:0]                     freeCount,
  output logic                              full,
  output logic                              releaseError
);
  logic [IW-1:0] fifo [ENTRY_NUM];
  logic [IW-1:0] head, tail;
  logic [CW-1:0] n_req, n_rel;
  logic [IW-1:0] rel_idx [RELEASE_WIDTH];
  logic [CW:0]   rel_sum;
  logic          ovf;
  // compacted lane ranks select consecutive free entries starting at head
  always_comb begin
    n_req = '0;
    allocPtr = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      allocPtr[i] = fifo[head + n_req[IW-1:0]];
      n_req = n_req + CW'(allocReq[i]);
    end
  end
  // released entries are appended at tail in lane order
  always_comb begin
    n_rel = '0;
    for (int i = 0; i < RELEASE_WIDTH; i++) begin
      rel_idx[i] = tail + n_rel[IW-1:0];
      n_rel = n_rel + CW'(releaseReq[i]);
    end
  end
  assign allocOK = !stall && !flush && (n_req <= freeCount);
  assign rel_sum = {1'b0, freeCount} + {1'b0, n_rel};
  assign ovf = rel_sum > (CW+1)'(ENTRY_NUM);
  assign full = freeCount == '0;
  // free-list state; reset and flush both restore the identity list
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      freeCount <= CW'(ENTRY_NUM);
      releaseError <= 1'b0;
      for (int k = 0; k < ENTRY_NUM; k++) fifo[k] <= IW'(k);
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      freeCount <= CW'(ENTRY_NUM);
      releaseError <= 1'b0;
      for (int k = 0; k < ENTRY_NUM; k++) fifo[k] <= IW'(k);
    end else begin
      if (allocOK) head <= head + n_req[IW-1:0];
      if (ovf) releaseError <= 1'b1;
      else begin
        tail <= tail + n_rel[IW-1:0];
        for (int i = 0; i < RELEASE_WIDTH; i++)
          if (releaseReq[i]) fifo[rel_idx[i]] <= releasePtr[i];
      end
      freeCount <= freeCount - (allocOK ? n_req : '0) + (ovf ? '0 : n_rel);
    end
  end
endmodule
